// File: rtl/team_08_wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// team_08_wb_master_arbiter
//
// Purpose:
//   Shares the team's single Wishbone master port between NUM_REQ internal
//   requesters. Grants are round-robin, and only one transaction is
//   outstanding at a time. The winner's payload is registered onto the bus at
//   grant time. The sequence is IDLE -> BUS -> RECOVER -> IDLE.
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   req_i[N]           level request per requester (held until ack_o/err_o)
//   req_adr_i[32N]     address, requester i at [32i+:32]
//   req_dat_i[32N]     write data, requester i at [32i+:32]
//   req_sel_i[4N]      byte selects, requester i at [4i+:4]
//   req_we_i[N]        1 = write, 0 = read
//   ack_o[N]           one-cycle completion pulse to the granted requester
//   err_o[N]           one-cycle timeout pulse (always 0 without the timeout)
//   rdata_o[32]        read data captured on ACK_I, held until next read ack
//   busy_o             high in BUS and RECOVER
//   ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O   registered Wishbone master outputs
//   DAT_I, ACK_I       Wishbone read data / acknowledge
//
// Configuration:
//   TEAM_08_WB_ARB_TIMEOUT_EN  when defined, a transaction that waits
//   TIMEOUT_CYCLES BUS cycles with no ACK_I is aborted and reported on err_o.
//   When undefined, BUS waits for ACK_I indefinitely and err_o is tied to 0.
// -----------------------------------------------------------------------------
module team_08_wb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [32*NUM_REQ-1:0] req_adr_i,
  input  logic [32*NUM_REQ-1:0] req_dat_i,
  input  logic [4*NUM_REQ-1:0]  req_sel_i,
  input  logic [NUM_REQ-1:0]    req_we_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [NUM_REQ-1:0]    err_o,
  output logic [31:0]           rdata_o,
  output logic                  busy_o,
  output logic [31:0]           ADR_O,
  output logic [31:0]           DAT_O,
  output logic [3:0]            SEL_O,
  output logic                  WE_O,
  output logic                  STB_O,
  output logic                  CYC_O,
  input  logic [31:0]           DAT_I,
  input  logic                  ACK_I
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic               stb_q, stb_d;
  logic               cyc_q, cyc_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  // Per-requester views of the flattened payload buses.
  logic [31:0] adr_arr [NUM_REQ];
  logic [31:0] dat_arr [NUM_REQ];
  logic [3:0]  sel_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign adr_arr[gi] = req_adr_i[32*gi +: 32];
      assign dat_arr[gi] = req_dat_i[32*gi +: 32];
      assign sel_arr[gi] = req_sel_i[4*gi +: 4];
    end
  endgenerate

  // Round-robin pick: first set request scanning upward from ptr_q, wrapping.
  // ptr_after is the pointer value that follows this winner.
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] ptr_after;

  always_comb begin
    int idx;
    int nxt;
    found     = 1'b0;
    pick      = ptr_q;
    idx       = 0;
    nxt       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    nxt = int'(pick) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    ptr_after = IDX_W'(nxt);
  end

`ifdef TEAM_08_WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]        to_cnt_q, to_cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    rdata_d = rdata_q;
    ack_d   = '0;
`ifdef TEAM_08_WB_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    err_d    = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = pick;
          ptr_d   = ptr_after;
          adr_d   = adr_arr[pick];
          dat_d   = dat_arr[pick];
          sel_d   = sel_arr[pick];
          we_d    = req_we_i[pick];
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = S_BUS;
`ifdef TEAM_08_WB_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      S_BUS: begin
        if (ACK_I) begin
          // ACK wins over a timeout landing on the same cycle.
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          if (!we_q) rdata_d = DAT_I;
          ack_d[win_q] = 1'b1;
          state_d      = S_RECOVER;
        end
`ifdef TEAM_08_WB_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          err_d[win_q] = 1'b1;
          state_d      = S_RECOVER;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
      S_RECOVER: begin
        // Gives the requester the ack_o cycle to drop req_i before rearbitration.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      rdata_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

`ifdef TEAM_08_WB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      to_cnt_q <= '0;
      err_q    <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign busy_o  = (state_q != S_IDLE);
  assign ADR_O   = adr_q;
  assign DAT_O   = dat_q;
  assign SEL_O   = sel_q;
  assign WE_O    = we_q;
  assign STB_O   = stb_q;
  assign CYC_O   = cyc_q;

endmodule

// File: tb/tb_team_08_wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_team_08_wb_master_arbiter
//
// Directed bench for team_08_wb_master_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
// Inputs change 1 ns after a rising edge and outputs are sampled there too, so
// every check observes the state registered by the preceding edge.
// Defining TEAM_08_WB_ARB_TIMEOUT_EN selects the timeout scenario instead of
// the long no-ACK wait.
// -----------------------------------------------------------------------------
module tb_team_08_wb_master_arbiter;

  logic        clk;
  logic        nrst;
  logic [1:0]  req_i;
  logic [63:0] req_adr_i;
  logic [63:0] req_dat_i;
  logic [7:0]  req_sel_i;
  logic [1:0]  req_we_i;
  logic [1:0]  ack_o;
  logic [1:0]  err_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  int checks = 0;
  int errors = 0;

  team_08_wb_master_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_i     (req_i),
    .req_adr_i (req_adr_i),
    .req_dat_i (req_dat_i),
    .req_sel_i (req_sel_i),
    .req_we_i  (req_we_i),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .busy_o    (busy_o),
    .ADR_O     (ADR_O),
    .DAT_O     (DAT_O),
    .SEL_O     (SEL_O),
    .WE_O      (WE_O),
    .STB_O     (STB_O),
    .CYC_O     (CYC_O),
    .DAT_I     (DAT_I),
    .ACK_I     (ACK_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [31:0] exp_adr [4];
    logic [1:0]  exp_ack [4];
    int          cyc_cnt;
    int          err_cnt;
    int          ack_cnt;
    int          low_cnt;

    exp_adr[0] = 32'h1000_0000; exp_ack[0] = 2'b01;
    exp_adr[1] = 32'h2000_0000; exp_ack[1] = 2'b10;
    exp_adr[2] = 32'h1000_0000; exp_ack[2] = 2'b01;
    exp_adr[3] = 32'h2000_0000; exp_ack[3] = 2'b10;

    nrst      = 1'b0;
    req_i     = 2'b00;
    req_adr_i = '0;
    req_dat_i = '0;
    req_sel_i = '0;
    req_we_i  = 2'b00;
    DAT_I     = '0;
    ACK_I     = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_cyc",   32'(CYC_O),  32'd0);
    check("rst_stb",   32'(STB_O),  32'd0);
    check("rst_ack",   32'(ack_o),  32'd0);
    check("rst_err",   32'(err_o),  32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_adr",   ADR_O,       32'd0);
    check("rst_rdata", rdata_o,     32'd0);
    nrst = 1'b1;
    tick();

    // ---------------- read from requester 0, ACK 3 cycles after CYC ----------------
    req_adr_i[31:0] = 32'h3000_0010;
    req_sel_i[3:0]  = 4'hF;
    req_we_i[0]     = 1'b0;
    req_i           = 2'b01;
    tick();
    check("rd_cyc_rise", 32'(CYC_O),  32'd1);
    check("rd_stb_rise", 32'(STB_O),  32'd1);
    check("rd_adr",      ADR_O,       32'h3000_0010);
    check("rd_we",       32'(WE_O),   32'd0);
    check("rd_busy",     32'(busy_o), 32'd1);
    tick();
    check("rd_cyc_w1",   32'(CYC_O),  32'd1);
    check("rd_ack_w1",   32'(ack_o),  32'd0);
    tick();
    check("rd_cyc_w2",   32'(CYC_O),  32'd1);
    ACK_I = 1'b1;
    DAT_I = 32'hDEAD_BEEF;
    tick();
    check("rd_cyc_fall", 32'(CYC_O),  32'd0);
    check("rd_stb_fall", 32'(STB_O),  32'd0);
    check("rd_ack",      32'(ack_o),  32'b01);
    check("rd_rdata",    rdata_o,     32'hDEAD_BEEF);
    check("rd_busy_rec", 32'(busy_o), 32'd1);
    ACK_I = 1'b0;
    DAT_I = 32'h0BAD_0BAD;
    req_i = 2'b00;
    tick();
    check("rd_ack_pulse", 32'(ack_o),  32'd0);
    check("rd_busy_idle", 32'(busy_o), 32'd0);
    check("rd_adr_hold",  ADR_O,       32'h3000_0010);
    check("rd_rdata_hold", rdata_o,    32'hDEAD_BEEF);

    // ---------------- write from requester 1 ----------------
    req_adr_i[63:32] = 32'h4000_0020;
    req_dat_i[63:32] = 32'h1234_5678;
    req_sel_i[7:4]   = 4'b0011;
    req_we_i[1]      = 1'b1;
    req_i            = 2'b10;
    tick();
    check("wr_cyc", 32'(CYC_O), 32'd1);
    check("wr_we",  32'(WE_O),  32'd1);
    check("wr_adr", ADR_O,      32'h4000_0020);
    check("wr_dat", DAT_O,      32'h1234_5678);
    check("wr_sel", 32'(SEL_O), 32'b0011);
    tick();
    check("wr_we_hold",  32'(WE_O),  32'd1);
    check("wr_dat_hold", DAT_O,      32'h1234_5678);
    check("wr_sel_hold", 32'(SEL_O), 32'b0011);
    ACK_I = 1'b1;
    DAT_I = 32'hCAFE_F00D;
    tick();
    check("wr_ack",        32'(ack_o), 32'b10);
    check("wr_we_fall",    32'(WE_O),  32'd0);
    check("wr_rdata_keep", rdata_o,    32'hDEAD_BEEF);
    ACK_I = 1'b0;
    req_i = 2'b00;
    tick();
    check("wr_ack_pulse", 32'(ack_o), 32'd0);

    // ---------------- async reset mid-BUS (ptr left at 1 beforehand) ----------------
    req_i = 2'b01;
    tick();
    check("mr_cyc_before", 32'(CYC_O), 32'd1);
    nrst = 1'b0;
    #1;
    check("mr_cyc_async",  32'(CYC_O),  32'd0);
    check("mr_stb_async",  32'(STB_O),  32'd0);
    check("mr_ack_async",  32'(ack_o),  32'd0);
    check("mr_busy_async", 32'(busy_o), 32'd0);
    req_adr_i[31:0]  = 32'h1000_0000;
    req_adr_i[63:32] = 32'h2000_0000;
    req_we_i         = 2'b00;
    req_i            = 2'b11;
    tick();
    nrst = 1'b1;

    // ---------------- round robin, both requests held, 1-cycle ACK ----------------
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("rr%0d_cyc", t), 32'(CYC_O), 32'd1);
      check($sformatf("rr%0d_adr", t), ADR_O,      exp_adr[t]);
      ACK_I = 1'b1;
      DAT_I = 32'hA500_0000 | 32'(t);
      tick();
      check($sformatf("rr%0d_ack", t),   32'(ack_o), 32'(exp_ack[t]));
      check($sformatf("rr%0d_rdata", t), rdata_o,    32'hA500_0000 | 32'(t));
      check($sformatf("rr%0d_gap1", t),  32'(CYC_O), 32'd0);
      ACK_I = 1'b0;
      tick();
      check($sformatf("rr%0d_gap2", t),  32'(CYC_O), 32'd0);
      check($sformatf("rr%0d_ackoff", t), 32'(ack_o), 32'd0);
    end
    req_i = 2'b00;

    // ---------------- ACK_I outside BUS is ignored ----------------
    tick();
    tick();
    ACK_I = 1'b1;
    DAT_I = 32'h5555_AAAA;
    tick();
    check("ign_ack1", 32'(ack_o), 32'd0);
    tick();
    check("ign_ack2",   32'(ack_o), 32'd0);
    check("ign_rdata",  rdata_o,    32'hA500_0003);
    check("ign_cyc",    32'(CYC_O), 32'd0);
    ACK_I = 1'b0;
    tick();

    // ---------------- no ACK_I at all ----------------
    req_adr_i[31:0] = 32'h3000_0010;
    req_i           = 2'b01;
    tick();
    check("to_cyc_rise", 32'(CYC_O), 32'd1);
`ifdef TEAM_08_WB_ARB_TIMEOUT_EN
    cyc_cnt = 1;
    err_cnt = 0;
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (err_o != 2'b00) begin
        err_cnt++;
        check("to_err_bit", 32'(err_o), 32'b01);
        req_i = 2'b00;
      end
      if (ack_o != 2'b00) ack_cnt++;
      if (CYC_O) cyc_cnt++;
    end
    check("to_cyc_len",  32'(cyc_cnt), 32'd8);
    check("to_err_cnt",  32'(err_cnt), 32'd1);
    check("to_ack_cnt",  32'(ack_cnt), 32'd0);
    check("to_rdata",    rdata_o,      32'hA500_0003);
    check("to_busy_end", 32'(busy_o),  32'd0);
`else
    low_cnt = 0;
    err_cnt = 0;
    ack_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!CYC_O) low_cnt++;
      if (err_o != 2'b00) err_cnt++;
      if (ack_o != 2'b00) ack_cnt++;
    end
    check("noto_cyc_low_cnt", 32'(low_cnt), 32'd0);
    check("noto_err_cnt",     32'(err_cnt), 32'd0);
    check("noto_ack_cnt",     32'(ack_cnt), 32'd0);
    check("noto_busy",        32'(busy_o),  32'd1);
    ACK_I = 1'b1;
    DAT_I = 32'h7777_0001;
    tick();
    check("noto_late_ack",   32'(ack_o), 32'b01);
    check("noto_late_rdata", rdata_o,    32'h7777_0001);
    ACK_I = 1'b0;
    req_i = 2'b00;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
